// File: rtl/viterbi_traceback.sv
// -----------------------------------------------------------------------------
// viterbi_traceback
//
// Purpose:
//   Traceback unit placed directly after the Viterbi survivor memory. A start
//   pulse latches the newest survivor row (start_time) and a starting state.
//   The unit then walks the survivor bits backwards for TB_LEN steps through
//   the memory's combinational read port. It presents one decoded bit per
//   traceback on a valid/ready output handshake. busy goes back to the
//   ACS/write controller so that it can throttle writes during a walk.
//
// Optional feature (macro VITERBI_TB_BEST_STATE_EN):
//   defined   - the traceback starts from best_state.
//   undefined - the traceback always starts from state 0 (fixed-start
//               traceback that relies on TB_LEN convergence). The best_state
//               port stays present but is unused.
//
// Ports:
//   clk          in   clock
//   rst          in   synchronous, active-high reset
//   start        in   single-cycle traceback request, sampled only in IDLE
//   start_time   in   survivor memory row of the newest survivor row
//   best_state   in   best-metric state at start_time
//   busy         out  high whenever the FSM is not IDLE
//   rd_state     out  registered state index into the survivor memory
//   rd_time      out  registered row index into the survivor memory
//   surv_bit     in   survivor bit at (rd_time, rd_state), same cycle
//   out_valid    out  decoded bit available
//   out_ready    in   consumer accepts out_bit
//   out_bit      out  decoded information bit
//   out_time     out  memory row that the decoded bit belongs to
//   dbg_state_o  out  current FSM state (IDLE=0, WALK=1, OUT=2)
//
// Output handshake: out_bit/out_time are transferred on a rising clk edge
// where out_valid && out_ready. Once out_valid is raised, out_valid,
// out_bit and out_time stay constant until that transfer happens. out_valid
// never depends combinationally on out_ready.
// -----------------------------------------------------------------------------
module viterbi_traceback #(
    parameter int K      = 5,
    parameter int M      = K - 1,
    parameter int S      = 1 << M,
    parameter int D      = 10,
    parameter int TB_LEN = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [$clog2(D)-1:0] start_time,
    input  logic [M-1:0]         best_state,
    output logic                 busy,
    output logic [$clog2(S)-1:0] rd_state,
    output logic [$clog2(D)-1:0] rd_time,
    input  logic                 surv_bit,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_bit,
    output logic [$clog2(D)-1:0] out_time,
    output logic [1:0]           dbg_state_o
);

    localparam int TW = $clog2(D);
    localparam int SW = $clog2(S);
    // The counter holds values up to TB_LEN, so it never wraps mid-walk.
    localparam int CW = $clog2(TB_LEN + 1);

    localparam logic [TW-1:0] T_LAST    = TW'(D - 1);
    localparam logic [CW-1:0] STEP_LAST = CW'(TB_LEN - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WALK = 2'd1;
    localparam logic [1:0] ST_OUT  = 2'd2;

    // Reject illegal configurations at elaboration time. The walk must leave
    // at least one row of slack so that the write controller can make progress.
    if (TB_LEN < 1 || TB_LEN > D - 1) begin : g_bad_tb_len
        $error("viterbi_traceback: TB_LEN must lie in 1..D-1");
    end
    if (M < 2 || SW != M) begin : g_bad_m
        $error("viterbi_traceback: need M >= 2 and S == 1 << M");
    end

    logic [1:0]    state_q,     state_d;
    logic [SW-1:0] rd_state_q,  rd_state_d;
    logic [TW-1:0] rd_time_q,   rd_time_d;
    logic [CW-1:0] step_q,      step_d;
    logic          out_valid_q, out_valid_d;
    logic          out_bit_q,   out_bit_d;
    logic [TW-1:0] out_time_q,  out_time_d;

    logic [SW-1:0] start_state;
    logic [SW-1:0] next_state;
    logic [TW-1:0] next_time;

`ifdef VITERBI_TB_BEST_STATE_EN
    assign start_state = best_state;
`else
    // Fixed-start traceback. best_state is folded into an unused sink so
    // that the port stays present without driving any logic.
    logic unused_best_state;
    assign unused_best_state = ^best_state;
    assign start_state       = '0;
`endif

    // One trellis step backwards. The survivor bit becomes the MSB of the
    // predecessor state, and the remaining state bits shift down.
    assign next_state = {surv_bit, rd_state_q[SW-1:1]};

    // Row index decrements modulo D. The explicit wrap keeps this correct
    // when D is not a power of two.
    assign next_time = (rd_time_q == '0) ? T_LAST : (rd_time_q - 1'b1);

    always_comb begin
        state_d     = state_q;
        rd_state_d  = rd_state_q;
        rd_time_d   = rd_time_q;
        step_d      = step_q;
        out_valid_d = out_valid_q;
        out_bit_d   = out_bit_q;
        out_time_d  = out_time_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_WALK;
                    rd_time_d  = start_time;
                    rd_state_d = start_state;
                    step_d     = '0;
                end
            end

            ST_WALK: begin
                rd_state_d = next_state;
                rd_time_d  = next_time;
                step_d     = step_q + 1'b1;
                // The last walk cycle captures the decoded bit. It is the LSB
                // of the oldest predecessor state, which is the information
                // bit that was shifted in at that row.
                if (step_q == STEP_LAST) begin
                    state_d     = ST_OUT;
                    out_valid_d = 1'b1;
                    out_bit_d   = next_state[0];
                    out_time_d  = next_time;
                end
            end

            ST_OUT: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rd_state_q  <= '0;
            rd_time_q   <= '0;
            step_q      <= '0;
            out_valid_q <= 1'b0;
            out_bit_q   <= 1'b0;
            out_time_q  <= '0;
        end else begin
            state_q     <= state_d;
            rd_state_q  <= rd_state_d;
            rd_time_q   <= rd_time_d;
            step_q      <= step_d;
            out_valid_q <= out_valid_d;
            out_bit_q   <= out_bit_d;
            out_time_q  <= out_time_d;
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign rd_state    = rd_state_q;
    assign rd_time     = rd_time_q;
    assign out_valid   = out_valid_q;
    assign out_bit     = out_bit_q;
    assign out_time    = out_time_q;
    assign dbg_state_o = state_q;

    // Protocol properties: a stalled output holds its value, and row indices
    // always stay inside the memory.
    a_out_hold: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_bit) && $stable(out_time)));

    a_rd_time_range: assert property (@(posedge clk) disable iff (rst)
        (rd_time <= T_LAST) && (out_time <= T_LAST));

endmodule

// File: tb/tb_viterbi_traceback.sv
// -----------------------------------------------------------------------------
// tb_viterbi_traceback
//
// Bench for viterbi_traceback. A survivor memory array feeds surv_bit
// combinationally. A reference traceback model computes the expected read
// sequence and the expected decoded bit and row from the memory contents.
// A monitor at the falling edge checks the read port during WALK and each
// output transfer against the expected queues.
// -----------------------------------------------------------------------------
module tb_viterbi_traceback;

    localparam int K      = 5;
    localparam int M      = K - 1;
    localparam int S      = 1 << M;
    localparam int D      = 10;
    localparam int TB_LEN = 6;
    localparam int TW     = $clog2(D);
    localparam int SW     = $clog2(S);

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [TW-1:0] start_time = '0;
    logic [M-1:0]  best_state = '0;
    logic          busy;
    logic [SW-1:0] rd_state;
    logic [TW-1:0] rd_time;
    logic          surv_bit;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          out_bit;
    logic [TW-1:0] out_time;
    logic [1:0]    dbg_state;

    always #5 clk = ~clk;

    viterbi_traceback #(.K(K), .M(M), .S(S), .D(D), .TB_LEN(TB_LEN)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_time (start_time),
        .best_state (best_state),
        .busy       (busy),
        .rd_state   (rd_state),
        .rd_time    (rd_time),
        .surv_bit   (surv_bit),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_bit    (out_bit),
        .out_time   (out_time),
        .dbg_state_o(dbg_state)
    );

    // Survivor memory model: one S-bit row per time index.
    logic [S-1:0] mem [D];
    assign surv_bit = (int'(rd_time) < D) ? mem[rd_time][rd_state] : 1'b0;

    // ---------------- scoreboard state ----------------
    logic [TW+SW-1:0] rd_q[$];   // {row, state} per WALK cycle
    logic [TW:0]      exp_q[$];  // {row, bit} per decoded output
    int total = 0;
    int bad   = 0;
    int n_out = 0;
    int n_exp = 0;
    bit rand_ready = 1'b0;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int start_state_of(input int bs);
`ifdef VITERBI_TB_BEST_STATE_EN
        return bs;
`else
        return 0 * bs;
`endif
    endfunction

    // Walk backwards from (t0, s0): each step prepends the survivor bit as
    // the new MSB of the state and steps the row back by one, modulo D.
    function automatic void expect_walk(input int t0, input int s0);
        int t = t0;
        int s = s0;
        int b;
        for (int i = 0; i < TB_LEN; i++) begin
            rd_q.push_back({TW'(t), SW'(s)});
            b = int'(mem[t][s]);
            s = (b << (M - 1)) | (s >> 1);
            t = (t + D - 1) % D;
        end
        exp_q.push_back({TW'(t), s[0]});
        n_exp++;
    endfunction

    // ---------------- driver tasks ----------------
    // Inputs change 1 time unit after the rising edge. The monitor samples
    // at the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    endtask

    // The caller guarantees that the DUT is idle, so this start is accepted.
    task automatic issue(input int t, input int bs);
        start_time = TW'(t);
        best_state = M'(bs);
        start      = 1'b1;
        expect_walk(t, start_state_of(bs));
        tick();
        start = 1'b0;
    endtask

    // A start pulse while the DUT is busy. It must be ignored.
    task automatic pulse_ignored(input int t, input int bs);
        start_time = TW'(t);
        best_state = M'(bs);
        start      = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        if (busy) check({name, "_idle_timeout"}, 1, 0);
    endtask

    task automatic fill_mem(input int mode);
        for (int d = 0; d < D; d++) begin
            if (mode == 0)      mem[d] = '0;
            else if (mode == 1) mem[d] = '1;
            else                mem[d] = S'($urandom);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [TW+SW-1:0] r;
        logic [TW:0]      e;
        if (!rst) begin
            // busy without out_valid is exactly the walk phase.
            if (busy && !out_valid) begin
                if (rd_q.size() == 0) begin
                    check("rd_unexpected_walk", 1, 0);
                end else begin
                    r = rd_q.pop_front();
                    check("rd_time", int'(rd_time), int'(r[TW+SW-1:SW]));
                    check("rd_state", int'(rd_state), int'(r[SW-1:0]));
                end
            end
            if (out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    check("out_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_time", int'(out_time), int'(e[TW:1]));
                    check("out_bit", int'(out_bit), int'(e[0]));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [TW:0] e;
        int n;
        fill_mem(0);

        // Reset state.
        rst = 1'b1;
        tick();
        tick();
        check("rst_busy", int'(busy), 0);
        check("rst_rd_state", int'(rd_state), 0);
        check("rst_rd_time", int'(rd_time), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_bit", int'(out_bit), 0);
        check("rst_out_time", int'(out_time), 0);
        rst = 1'b0;
        tick();

        // All-zero memory from row 3. The latency count includes the edge
        // that accepts start, so out_valid is first seen after edge 7.
        fill_mem(0);
        out_ready = 1'b1;
        issue(3, 4'b1011);
        for (int i = 2; i <= TB_LEN + 1; i++) begin
            tick();
            if (i == TB_LEN)     check("lat_not_yet", int'(out_valid), 0);
            if (i == TB_LEN + 1) check("lat_valid", int'(out_valid), 1);
        end
        // The handshake completes on this edge. The simultaneous start is
        // ignored because the DUT is still in OUT.
        pulse_ignored(1, 2);
        check("same_edge_start_ignored", int'(busy), 0);
        wait_idle("t1");

        // All-one memory, start state 0.
        fill_mem(1);
        issue(3, 0);
        wait_idle("t2");

        // Row wrap from start_time 0.
        fill_mem(0);
        issue(0, 5);
        wait_idle("t3");

        // best_state is ignored when the feature is off.
        fill_mem(0);
        issue(2, 4'b1111);
        wait_idle("t4");

        // Backpressure: hold out_ready low in OUT, with an ignored start.
        fill_mem(2);
        out_ready = 1'b0;
        issue(5, 6);
        e = exp_q[$];
        n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        check("bp_valid_seen", int'(out_valid), 1);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", int'(out_valid), 1);
            check("bp_bit", int'(out_bit), int'(e[0]));
            check("bp_time", int'(out_time), int'(e[TW:1]));
            check("bp_busy", int'(busy), 1);
            if (i == 1) pulse_ignored(8, 3);
            else        tick();
        end
        out_ready = 1'b1;
        tick();
        check("bp_release_idle", int'(busy), 0);
        check("bp_release_valid", int'(out_valid), 0);
        issue(7, 9);
        wait_idle("bp_after");

        // Reset in the middle of a walk drops the traceback.
        fill_mem(2);
        issue(4, 12);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_valid", int'(out_valid), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_rd_state", int'(rd_state), 0);
        check("mid_rst_rd_time", int'(rd_time), 0);
        rd_q.delete();
        exp_q.delete();
        n_exp--;
        for (int i = 0; i < 10; i++) tick();
        check("mid_rst_stays_idle", int'(busy), 0);

        // Randomized tracebacks with random backpressure and ignored starts.
        rand_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            wait_idle("rand");
            fill_mem(2);
            issue($urandom_range(0, D - 1), $urandom_range(0, S - 1));
            if ($urandom_range(0, 1) == 1)
                pulse_ignored($urandom_range(0, D - 1), $urandom_range(0, S - 1));
        end
        wait_idle("drain");
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        for (int i = 0; i < 5; i++) tick();

        check("exp_q_empty", exp_q.size(), 0);
        check("rd_q_empty", rd_q.size(), 0);
        check("out_count", n_out, n_exp);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
